// File: rtl/usbbootrom_reader.sv
// Burst read initiator for the USB boot ROM macro: validates byte-addressed
// requests, paces ROM reads against a small response FIFO, and returns beats.
module usbbootrom_reader #(
   parameter int ADDR_WIDTH = 17,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 73728,
   parameter int LEN_WIDTH  = 4,
   parameter int BUF_DEPTH  = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH+1:0] req_addr,
   input  logic [LEN_WIDTH-1:0]  req_len,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_data,
   output logic                  resp_last,
   output logic                  resp_error,
   output logic                  rom_me,
   output logic                  rom_oe,
   output logic [ADDR_WIDTH-1:0] rom_address,
   input  logic [DATA_WIDTH-1:0] rom_q
);

   localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CNT_W = $clog2(BUF_DEPTH + 1);
   localparam logic [ADDR_WIDTH:0] DEPTH_W   = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [PTR_W-1:0]    PTR_LAST  = PTR_W'(BUF_DEPTH - 1);
   localparam logic [CNT_W:0]      BUF_LIMIT = (CNT_W+1)'(BUF_DEPTH);

   typedef enum logic [1:0] {IDLE, BURST, ERR, DRAIN} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic [LEN_WIDTH-1:0]  rem_q, rem_d;
   logic                  me_q, me_last_q, me_last_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [PTR_W-1:0]      wr_q, wr_d, rd_q, rd_d;
   logic [DATA_WIDTH-1:0] buf_data_q [BUF_DEPTH];
   logic [DATA_WIDTH-1:0] buf_data_d [BUF_DEPTH];
   logic                  buf_last_q [BUF_DEPTH];
   logic                  buf_last_d [BUF_DEPTH];

   logic [ADDR_WIDTH-1:0] req_waddr;
   logic [ADDR_WIDTH:0]   req_end;
   logic                  req_bad;
   logic                  buf_nonempty;
   logic                  buf_pop;
   logic                  push;
   logic                  issue_ok;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   // Range check is done one bit wider so waddr+len cannot wrap.
   assign req_waddr = req_addr[ADDR_WIDTH+1:2];
   assign req_end   = {1'b0, req_waddr} + (ADDR_WIDTH+1)'(req_len);
   assign req_bad   = (req_addr[1:0] != 2'b00) || (req_end >= DEPTH_W);

   assign buf_nonempty = (count_q != '0);
   assign buf_pop      = buf_nonempty && resp_ready;
   assign push         = me_q;

   assign req_ready   = (state_q == IDLE);
   assign resp_valid  = buf_nonempty || (state_q == ERR);
   assign resp_error  = (state_q == ERR);
   assign resp_data   = buf_nonempty ? buf_data_q[rd_q] : '0;
   assign resp_last   = (state_q == ERR) || (buf_nonempty && buf_last_q[rd_q]);
   assign rom_oe      = me_q;
   assign rom_address = ptr_q;

   // A read may issue only if its word is guaranteed a buffer slot on arrival.
   assign issue_ok = ({1'b0, count_q} + (CNT_W+1)'(me_q)) < (BUF_LIMIT + (CNT_W+1)'(buf_pop));

   // NOTE: every signal written here gets a default first, so no latch is inferred.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      rem_d     = rem_q;
      me_last_d = 1'b0;
      rom_me    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (req_bad) begin
                  state_d = ERR;
               end else begin
                  ptr_d   = req_waddr;
                  rem_d   = req_len;
                  state_d = BURST;
               end
            end
         end
         BURST: begin
            if (issue_ok) begin
               rom_me = 1'b1;
               ptr_d  = ptr_q + 1'b1;
               rem_d  = rem_q - 1'b1;
               if (rem_q == '0) begin
                  me_last_d = 1'b1;
                  state_d   = DRAIN;
               end
            end
         end
         ERR: begin
            if (resp_ready) state_d = IDLE;
         end
         DRAIN: begin
            if (buf_pop && buf_last_q[rd_q]) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      wr_d       = wr_q;
      rd_d       = rd_q;
      count_d    = count_q;
      buf_data_d = buf_data_q;
      buf_last_d = buf_last_q;
      if (push) begin
         buf_data_d[wr_q] = rom_q;
         buf_last_d[wr_q] = me_last_q;
         wr_d             = ptr_inc(wr_q);
      end
      if (buf_pop) rd_d = ptr_inc(rd_q);
      if (push && !buf_pop)      count_d = count_q + 1'b1;
      else if (!push && buf_pop) count_d = count_q - 1'b1;
   end

   // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         rem_q     <= '0;
         me_q      <= 1'b0;
         me_last_q <= 1'b0;
         count_q   <= '0;
         wr_q      <= '0;
         rd_q      <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         rem_q     <= rem_d;
         me_q      <= rom_me;
         me_last_q <= me_last_d;
         count_q   <= count_d;
         wr_q      <= wr_d;
         rd_q      <= rd_d;
      end
   end

   // NOTE: buffer storage is not reset; entries are only read while count_q says they hold data.
   always_ff @(posedge clock) begin
      buf_data_q <= buf_data_d;
      buf_last_q <= buf_last_d;
   end

endmodule
